// File: rtl/btn_step_ctrl.sv
// Button press/auto-repeat pulse generator and CPU clock-enable with single-step counting.
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined; otherwise each press gives one pulse.
module btn_step_ctrl #(
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  button,
  input  logic [7:0]  SW,
  output logic [4:0]  btn_pulse,
  output logic        sw_changed,
  output logic        cpu_en,
  output logic [15:0] step_cnt
);

  localparam int NB = 5;

  if (REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_param_check
    $error("btn_step_ctrl: REPEAT_DELAY and REPEAT_RATE must be at least 2");
  end

  logic [4:0]  btn_prev_q;
  logic [7:0]  sw_prev_q;
  logic [4:0]  pulse_d, pulse_q;
  logic        sw_changed_d, sw_changed_q;
  logic        cpu_en_d, cpu_en_q;
  logic [15:0] step_cnt_d, step_cnt_q;

`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_REPEAT  = 2'd2
  } btn_state_e;

  localparam logic [31:0] DELAY_LAST = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RATE_LAST  = 32'(REPEAT_RATE - 1);

  btn_state_e  state_q [NB];
  btn_state_e  state_d [NB];
  logic [31:0] cnt_q   [NB];
  logic [31:0] cnt_d   [NB];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (rst) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // A release always wins: back to IDLE with the counter cleared and no pulse.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (button[i] && !btn_prev_q[i]) begin
            state_d[i] = S_PRESSED;
            cnt_d[i]   = '0;
          end
        end
        S_PRESSED: begin
          if (!button[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DELAY_LAST) begin
            state_d[i] = S_REPEAT;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 32'd1;
          end
        end
        S_REPEAT: begin
          if (!button[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == RATE_LAST) begin
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 32'd1;
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < NB; i++) begin
      case (state_q[i])
        S_IDLE:    pulse_d[i] = button[i] && !btn_prev_q[i];
        S_PRESSED: pulse_d[i] = button[i] && (cnt_q[i] == DELAY_LAST);
        S_REPEAT:  pulse_d[i] = button[i] && (cnt_q[i] == RATE_LAST);
        default:   pulse_d[i] = 1'b0;
      endcase
    end
  end
`else
  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } btn_state_e;

  btn_state_e state_q [NB];
  btn_state_e state_d [NB];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (rst) state_q[i] <= S_IDLE;
      else     state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_IDLE:  if (button[i] && !btn_prev_q[i]) state_d[i] = S_HELD;
        S_HELD:  if (!button[i]) state_d[i] = S_IDLE;
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < NB; i++) begin
      if (state_q[i] == S_IDLE) pulse_d[i] = button[i] && !btn_prev_q[i];
    end
  end
`endif

  // Enable and step counter are derived from the same-edge pulse so they line up with btn_pulse.
  always_comb begin
    sw_changed_d = (SW != sw_prev_q);
    cpu_en_d     = SW[0] | pulse_d[0];
    step_cnt_d   = step_cnt_q;
    if (pulse_d[4]) begin
      step_cnt_d = '0;
    end else if (cpu_en_d && !SW[0]) begin
      step_cnt_d = step_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_q   <= '0;
      sw_prev_q    <= '0;
      pulse_q      <= '0;
      sw_changed_q <= 1'b0;
      cpu_en_q     <= 1'b0;
      step_cnt_q   <= '0;
    end else begin
      btn_prev_q   <= button;
      sw_prev_q    <= SW;
      pulse_q      <= pulse_d;
      sw_changed_q <= sw_changed_d;
      cpu_en_q     <= cpu_en_d;
      step_cnt_q   <= step_cnt_d;
    end
  end

  assign btn_pulse  = pulse_q;
  assign sw_changed = sw_changed_q;
  assign cpu_en     = cpu_en_q;
  assign step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Directed bench for btn_step_ctrl: a per-cycle vector table plus hand sequences for
// counter wrap, auto-repeat timing (or single pulse when built without it) and reset while held.
module tb_btn_step_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  button;
  logic [7:0]  SW;
  logic [4:0]  btn_pulse;
  logic        sw_changed;
  logic        cpu_en;
  logic [15:0] step_cnt;

  int total = 0;
  int bad   = 0;

  btn_step_ctrl #(
    .REPEAT_DELAY(8),
    .REPEAT_RATE (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .button    (button),
    .SW        (SW),
    .btn_pulse (btn_pulse),
    .sw_changed(sw_changed),
    .cpu_en    (cpu_en),
    .step_cnt  (step_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  b;
    logic [7:0]  sw;
    logic [4:0]  p;
    logic        swc;
    logic        en;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [4:0] b, input logic [7:0] sw,
                     input logic [4:0] p, input logic swc, input logic en, input logic [15:0] cnt);
    vec_t v;
    v.rst = r; v.b = b; v.sw = sw; v.p = p; v.swc = swc; v.en = en; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Driver: applies inputs at the negedge, then samples results at the following negedge.
  task automatic drive(input logic r, input logic [4:0] b, input logic [7:0] sw);
    rst = r; button = b; SW = sw;
    @(negedge clk);
  endtask

  logic [39:0] got;
  logic [39:0] exp;
  int          npulse;

  initial begin
    rst = 1'b1; button = '0; SW = '0;

    //   rst  button   SW       pulse    swc   en    step
    add(1, 5'h00, 8'h00, 5'h00, 0, 0, 16'd0);
    add(1, 5'h00, 8'h00, 5'h00, 0, 0, 16'd0);
    add(0, 5'h00, 8'h00, 5'h00, 0, 0, 16'd0);
    add(0, 5'h02, 8'h00, 5'h02, 0, 0, 16'd0);
    add(0, 5'h02, 8'h00, 5'h00, 0, 0, 16'd0);
    add(0, 5'h00, 8'h00, 5'h00, 0, 0, 16'd0);
    add(0, 5'h01, 8'h00, 5'h01, 0, 1, 16'd1);
    add(0, 5'h00, 8'h00, 5'h00, 0, 0, 16'd1);
    add(0, 5'h01, 8'h00, 5'h01, 0, 1, 16'd2);
    add(0, 5'h00, 8'h00, 5'h00, 0, 0, 16'd2);
    add(0, 5'h01, 8'h00, 5'h01, 0, 1, 16'd3);
    add(0, 5'h01, 8'h00, 5'h00, 0, 0, 16'd3);
    add(0, 5'h00, 8'h00, 5'h00, 0, 0, 16'd3);
    add(0, 5'h10, 8'h00, 5'h10, 0, 0, 16'd0);
    add(0, 5'h00, 8'h00, 5'h00, 0, 0, 16'd0);
    add(0, 5'h11, 8'h00, 5'h11, 0, 1, 16'd0);
    add(0, 5'h00, 8'h00, 5'h00, 0, 0, 16'd0);
    add(0, 5'h00, 8'h01, 5'h00, 1, 1, 16'd0);
    add(0, 5'h00, 8'h01, 5'h00, 0, 1, 16'd0);
    add(0, 5'h01, 8'h01, 5'h01, 0, 1, 16'd0);
    add(0, 5'h00, 8'h01, 5'h00, 0, 1, 16'd0);
    add(0, 5'h10, 8'h01, 5'h10, 0, 1, 16'd0);
    add(0, 5'h00, 8'h00, 5'h00, 1, 0, 16'd0);
    add(0, 5'h00, 8'h81, 5'h00, 1, 1, 16'd0);
    add(0, 5'h00, 8'h81, 5'h00, 0, 1, 16'd0);
    add(0, 5'h00, 8'h80, 5'h00, 1, 0, 16'd0);
    add(0, 5'h00, 8'h80, 5'h00, 0, 0, 16'd0);
    add(0, 5'h1f, 8'h80, 5'h1f, 0, 1, 16'd0);
    add(0, 5'h00, 8'h80, 5'h00, 0, 0, 16'd0);
    add(0, 5'h04, 8'h00, 5'h04, 1, 0, 16'd0);
    add(1, 5'h04, 8'h00, 5'h00, 0, 0, 16'd0);
    add(0, 5'h04, 8'h00, 5'h04, 0, 0, 16'd0);
    add(0, 5'h04, 8'h00, 5'h00, 0, 0, 16'd0);
    add(1, 5'h00, 8'h81, 5'h00, 0, 0, 16'd0);
    add(0, 5'h00, 8'h81, 5'h00, 1, 1, 16'd0);
    add(0, 5'h00, 8'h00, 5'h00, 1, 0, 16'd0);
    add(0, 5'h00, 8'h00, 5'h00, 0, 0, 16'd0);

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].b, vecs[i].sw);
      check("vec_pulse", i, 40'(btn_pulse),  40'(vecs[i].p));
      check("vec_swc",   i, 40'(sw_changed), 40'(vecs[i].swc));
      check("vec_en",    i, 40'(cpu_en),     40'(vecs[i].en));
      check("vec_step",  i, 40'(step_cnt),   40'(vecs[i].cnt));
    end

    // Counter wrap: hold the count at 0xFFFF across one edge, then single-step.
    force dut.step_cnt_q = 16'hFFFF;
    drive(0, 5'h00, 8'h00);
    release dut.step_cnt_q;
    drive(0, 5'h01, 8'h00);
    check("wrap_step", 0, 40'(step_cnt), 40'h0);
    check("wrap_en",   0, 40'(cpu_en),   40'h1);
    drive(0, 5'h00, 8'h00);

    // Hold button[0] for 30 sampled edges in step mode and record every pulse.
    got = '0;
    button = 5'h01;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      got[j] = btn_pulse[0];
      if (j == 29) button = 5'h00;
    end
`ifdef BTN_AUTOREPEAT_EN
    exp = '0;
    for (int j = 0; j <= 28; j += 4) begin
      if (j == 0 || j >= 8) exp[j] = 1'b1;
    end
    check("repeat_pattern", 0, got, exp);
    check("repeat_steps",   0, 40'(step_cnt), 40'd7);
`else
    exp = 40'h1;
    check("hold_pattern", 0, got, exp);
    check("hold_steps",   0, 40'(step_cnt), 40'd1);

    npulse = 0;
    button = 5'h08;
    for (int j = 0; j < 1000; j++) begin
      @(negedge clk);
      if (btn_pulse[3]) npulse++;
    end
    button = 5'h00;
    check("hold1000_pulses", 0, 40'(npulse), 40'd1);
    @(negedge clk);
`endif

    // Reset while button[2] is held long past the repeat delay.
    button = 5'h04;
    repeat (14) @(negedge clk);
    drive(1, 5'h04, 8'h00);
    check("rst_pulse", 0, 40'(btn_pulse),  40'h0);
    check("rst_swc",   0, 40'(sw_changed), 40'h0);
    check("rst_en",    0, 40'(cpu_en),     40'h0);
    check("rst_step",  0, 40'(step_cnt),   40'h0);
    drive(0, 5'h04, 8'h00);
    check("rst_repress", 0, 40'(btn_pulse), 40'h04);
    drive(0, 5'h04, 8'h00);
    check("rst_held",    0, 40'(btn_pulse), 40'h00);
    drive(0, 5'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
